// File: rtl/hardfloat_test_sequencer.sv
// Feeds test vectors to a hardfloat unit and checks its in-order results against a FIFO of expectations.
// Result -> record/counters in 1 cycle; issue stalls on dut_in_ready low or a full in-flight FIFO.
module hardfloat_test_sequencer #(
  parameter int DATA_W          = 33,
  parameter int FLAGS_W         = 5,
  parameter int DEPTH           = 8,
  parameter int MAX_ERRORS      = 20,
  parameter int REPORT_INTERVAL = 10000,
  parameter int CNT_W           = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               vec_valid,
  output logic               vec_ready,
  input  logic               vec_last,
  input  logic [DATA_W-1:0]  vec_expected,
  input  logic [FLAGS_W-1:0] vec_exp_flags,
  output logic               dut_in_valid,
  input  logic               dut_in_ready,
  input  logic               dut_out_valid,
  input  logic [DATA_W-1:0]  dut_out_data,
  input  logic [FLAGS_W-1:0] dut_out_flags,
  output logic               mismatch_valid,
  output logic [CNT_W-1:0]   mismatch_index,
  output logic [DATA_W-1:0]  mismatch_expected,
  output logic [DATA_W-1:0]  mismatch_actual,
  output logic [FLAGS_W-1:0] mismatch_exp_flags,
  output logic [FLAGS_W-1:0] mismatch_act_flags,
  output logic [CNT_W-1:0]   test_count,
  output logic [CNT_W-1:0]   error_count,
  output logic               progress,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic               proto_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      FULL_OCC  = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] ERR_LAST  = CNT_W'(MAX_ERRORS - 1);
  localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPORT_INTERVAL - 1);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE, ABORT} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0]  fifo_exp [DEPTH];
  logic [FLAGS_W-1:0] fifo_flg [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        occ, occ_nxt;
  logic               full, empty;

  logic               active, fire, pop, stray, cmp_pass, err_hit;
  logic [CNT_W-1:0]   rpt_cnt;

  assign active   = (state == RUN) || (state == DRAIN);
  assign fire     = (state == RUN) && vec_valid && dut_in_ready && !full;
  assign pop      = active && dut_out_valid && !empty;
  assign stray    = active && dut_out_valid && empty;
  // Case equality so any X/Z on the returned result is reported as a mismatch.
  assign cmp_pass = (dut_out_data === fifo_exp[rd_ptr]) && (dut_out_flags === fifo_flg[rd_ptr]);
  assign err_hit  = pop && !cmp_pass && (error_count == ERR_LAST);

  assign busy    = active;
  assign done    = (state == DONE);
  assign aborted = (state == ABORT);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    vec_ready    = 1'b0;
    dut_in_valid = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN: begin
        dut_in_valid = vec_valid && !full;
        vec_ready    = dut_in_ready && !full;
        if (fire && vec_last) state_nxt = DRAIN;
      end
      DRAIN: if (empty) state_nxt = DONE;
      default: ;
    endcase
    if (err_hit) state_nxt = ABORT;
  end

  always_ff @(posedge clk) begin
    if (fire) begin
      fifo_exp[wr_ptr] <= vec_expected;
      fifo_flg[wr_ptr] <= vec_exp_flags;
    end
  end

  assign occ_nxt = occ + {{AW{1'b0}}, fire} - {{AW{1'b0}}, pop};

  // full/empty come from the registered occupancy, so a pop never frees a slot the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (fire) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      occ   <= occ_nxt;
      full  <= (occ_nxt == FULL_OCC);
      empty <= (occ_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mismatch_valid     <= 1'b0;
      mismatch_index     <= '0;
      mismatch_expected  <= '0;
      mismatch_actual    <= '0;
      mismatch_exp_flags <= '0;
      mismatch_act_flags <= '0;
      test_count         <= '0;
      error_count        <= '0;
      rpt_cnt            <= '0;
      progress           <= 1'b0;
      proto_err          <= 1'b0;
    end else begin
      mismatch_valid <= 1'b0;
      progress       <= 1'b0;
      if (stray) proto_err <= 1'b1;
      if (pop) begin
        if (test_count != '1) begin
          test_count <= test_count + CNT_W'(1);
          if (rpt_cnt == RPT_LAST) begin
            rpt_cnt  <= '0;
            progress <= 1'b1;
          end else begin
            rpt_cnt <= rpt_cnt + CNT_W'(1);
          end
        end
        if (!cmp_pass) begin
          mismatch_valid     <= 1'b1;
          mismatch_index     <= test_count;
          mismatch_expected  <= fifo_exp[rd_ptr];
          mismatch_actual    <= dut_out_data;
          mismatch_exp_flags <= fifo_flg[rd_ptr];
          mismatch_act_flags <= dut_out_flags;
          if (error_count != '1) error_count <= error_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_hardfloat_test_sequencer.sv
// Bench for hardfloat_test_sequencer: a latency-3 fake DUT, a vector source and a mismatch scoreboard.
module tb_hardfloat_test_sequencer;

  localparam int DW   = 33;
  localparam int FW   = 5;
  localparam int CW   = 32;
  localparam int MAXE = 20;
  localparam int RPT  = 4;
  localparam int LAT  = 3;

  logic          clk, reset, start;
  logic          vec_valid, vec_ready, vec_last;
  logic [DW-1:0] vec_expected;
  logic [FW-1:0] vec_exp_flags;
  logic          dut_in_valid, dut_in_ready;
  logic          dut_out_valid;
  logic [DW-1:0] dut_out_data;
  logic [FW-1:0] dut_out_flags;
  logic          mismatch_valid;
  logic [CW-1:0] mismatch_index;
  logic [DW-1:0] mismatch_expected, mismatch_actual;
  logic [FW-1:0] mismatch_exp_flags, mismatch_act_flags;
  logic [CW-1:0] test_count, error_count;
  logic          progress, busy, done, aborted, proto_err;

  hardfloat_test_sequencer #(
    .DATA_W(DW), .FLAGS_W(FW), .DEPTH(8), .MAX_ERRORS(MAXE), .REPORT_INTERVAL(RPT), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_last(vec_last),
    .vec_expected(vec_expected), .vec_exp_flags(vec_exp_flags),
    .dut_in_valid(dut_in_valid), .dut_in_ready(dut_in_ready),
    .dut_out_valid(dut_out_valid), .dut_out_data(dut_out_data), .dut_out_flags(dut_out_flags),
    .mismatch_valid(mismatch_valid), .mismatch_index(mismatch_index),
    .mismatch_expected(mismatch_expected), .mismatch_actual(mismatch_actual),
    .mismatch_exp_flags(mismatch_exp_flags), .mismatch_act_flags(mismatch_act_flags),
    .test_count(test_count), .error_count(error_count), .progress(progress),
    .busy(busy), .done(done), .aborted(aborted), .proto_err(proto_err)
  );

  typedef struct { int idx; logic [DW-1:0] e; logic [DW-1:0] a; logic [FW-1:0] ef; logic [FW-1:0] af; } mm_t;
  typedef struct { logic [DW-1:0] d; logic [FW-1:0] f; int due; } res_t;
  typedef struct { int n; int bad; bit all_b; int tests; int errs; bit done_e; bit abort_e; } scn_t;

  mm_t  mq[$];
  res_t pq[$];

  logic [DW-1:0] v_exp [64];
  logic [FW-1:0] v_flg [64];

  int  checks = 0, errors = 0;
  int  cyc = 0;
  int  n_vec = 0, bad_idx = -1, src_idx = 0, fire_idx = 0, model_err = 0;
  int  mm_seen = 0, prog_cnt = 0, last_fire_cyc = 0, last_out_cyc = 0, release_cnt = 0;
  bit  all_bad = 0, src_en = 0, hold_out = 0, inject_stray = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Vector source: presents the next table entry whenever enabled.
  initial begin
    vec_valid = 0; vec_last = 0; vec_expected = '0; vec_exp_flags = '0;
    forever begin
      @(posedge clk); #1;
      if (reset || !src_en || src_idx >= n_vec) begin
        vec_valid = 0;
        vec_last  = 0;
      end else begin
        vec_valid     = 1;
        vec_expected  = v_exp[src_idx];
        vec_exp_flags = v_flg[src_idx];
        vec_last      = (src_idx == n_vec - 1);
      end
    end
  end

  // Fake DUT output side: returns queued results LAT cycles after issue, optionally held back.
  initial begin : dut_model
    res_t r;
    dut_out_valid = 0; dut_out_data = '0; dut_out_flags = '0;
    forever begin
      @(posedge clk); #1;
      dut_out_valid = 0;
      if (!reset) begin
        if (inject_stray) begin
          dut_out_valid = 1;
          dut_out_data  = {1'($urandom), 32'($urandom)};
          dut_out_flags = 5'($urandom);
          inject_stray  = 0;
        end else if (pq.size() > 0 && pq[0].due <= cyc && (!hold_out || release_cnt > 0)) begin
          r = pq.pop_front();
          dut_out_valid = 1;
          dut_out_data  = r.d;
          dut_out_flags = r.f;
          if (hold_out) release_cnt--;
        end
      end
    end
  end

  // Monitor: records fires, builds DUT results and expected mismatch records, checks outputs.
  initial begin : monitor
    res_t r;
    mm_t  m;
    forever begin
      @(negedge clk);
      if (reset) begin
        pq.delete(); mq.delete();
        fire_idx = 0; src_idx = 0; model_err = 0; mm_seen = 0; prog_cnt = 0;
      end else begin
        if (vec_valid && vec_ready) begin
          r.d = v_exp[fire_idx];
          r.f = v_flg[fire_idx];
          if (all_bad || fire_idx == bad_idx) begin
            if (all_bad && (fire_idx % 2 == 1)) r.f[fire_idx % 5] = ~r.f[fire_idx % 5];
            else r.d[(fire_idx * 5) % 33] = ~r.d[(fire_idx * 5) % 33];
            if (model_err < MAXE) begin
              m.idx = fire_idx; m.e = v_exp[fire_idx]; m.a = r.d; m.ef = v_flg[fire_idx]; m.af = r.f;
              mq.push_back(m);
              model_err++;
            end
          end
          r.due = cyc + LAT;
          pq.push_back(r);
          fire_idx++;
          src_idx++;
          last_fire_cyc = cyc;
        end
        if (dut_out_valid) last_out_cyc = cyc;
        if (progress) begin
          prog_cnt++;
          chk("progress_at_multiple", 64'((test_count % RPT == 0) && (test_count != 0)), 64'd1);
        end
        if (mismatch_valid) begin
          mm_seen++;
          if (mq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_mismatch: index %0d, none expected", mismatch_index);
          end else begin
            m = mq.pop_front();
            chk("mm_index",     mismatch_index,     64'(m.idx));
            chk("mm_expected",  mismatch_expected,  m.e);
            chk("mm_actual",    mismatch_actual,    m.a);
            chk("mm_exp_flags", mismatch_exp_flags, m.ef);
            chk("mm_act_flags", mismatch_act_flags, m.af);
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_reset(input string tag);
    chk({tag, "_vec_ready"},    vec_ready, 0);
    chk({tag, "_dut_in_valid"}, dut_in_valid, 0);
    chk({tag, "_mm_valid"},     mismatch_valid, 0);
    chk({tag, "_mm_index"},     mismatch_index, 0);
    chk({tag, "_mm_expected"},  mismatch_expected, 0);
    chk({tag, "_mm_actual"},    mismatch_actual, 0);
    chk({tag, "_mm_flags"},     {mismatch_exp_flags, mismatch_act_flags}, 0);
    chk({tag, "_test_count"},   test_count, 0);
    chk({tag, "_error_count"},  error_count, 0);
    chk({tag, "_status"},       {progress, busy, done, aborted, proto_err}, 0);
  endtask

  task automatic do_reset(input bit check, input string tag);
    @(posedge clk); #2;
    reset = 1; src_en = 0; start = 0; hold_out = 0; release_cnt = 0; inject_stray = 0;
    @(posedge clk); #2;
    reset = 0;
    @(negedge clk);
    if (check) check_reset(tag);
  endtask

  task automatic load_and_start(input int n, input int b, input bit a, input bit hold);
    n_vec = n; bad_idx = b; all_bad = a; hold_out = hold;
    for (int i = 0; i < n; i++) begin
      v_exp[i] = {1'($urandom), 32'($urandom)};
      v_flg[i] = 5'($urandom);
    end
    src_en = 1;
    start  = 1;
    @(posedge clk); #2;
    start = 0;
  endtask

  scn_t scn[4];

  initial begin
    reset = 1; start = 0; dut_in_ready = 1;
    scn[0] = '{5,  -1, 1'b0, 5,  0,    1'b1, 1'b0};
    scn[1] = '{5,   2, 1'b0, 5,  1,    1'b1, 1'b0};
    scn[2] = '{30, -1, 1'b1, 20, MAXE, 1'b0, 1'b1};
    scn[3] = '{9,  -1, 1'b0, 9,  0,    1'b1, 1'b0};

    do_reset(1, "por");

    for (int s = 0; s < 4; s++) begin
      do_reset(0, "");
      load_and_start(scn[s].n, scn[s].bad, scn[s].all_b, 0);
      for (int i = 0; i < 500 && !(done || aborted); i++) @(negedge clk);
      chk($sformatf("s%0d_finished", s), 64'(done || aborted), 1);
      repeat (12) @(negedge clk);
      chk($sformatf("s%0d_test_count", s),  test_count,  64'(scn[s].tests));
      chk($sformatf("s%0d_error_count", s), error_count, 64'(scn[s].errs));
      chk($sformatf("s%0d_done", s),        done,        64'(scn[s].done_e));
      chk($sformatf("s%0d_aborted", s),     aborted,     64'(scn[s].abort_e));
      chk($sformatf("s%0d_busy", s),        busy,        0);
      chk($sformatf("s%0d_mm_pulses", s),   64'(mm_seen),  64'(scn[s].errs));
      chk($sformatf("s%0d_mm_left", s),     64'(mq.size()), 0);
      chk($sformatf("s%0d_progress", s),    64'(prog_cnt), 64'(scn[s].tests / RPT));
      chk($sformatf("s%0d_no_issue", s),    {vec_ready, dut_in_valid}, 0);
      chk($sformatf("s%0d_proto_err", s),   proto_err,   0);
    end

    // FIFO fill: results held back, then a single result released.
    do_reset(0, "");
    load_and_start(40, -1, 0, 1);
    repeat (20) @(negedge clk);
    chk("bp_fires_when_full", 64'(fire_idx), 8);
    chk("bp_vec_ready_low", vec_ready, 0);
    chk("bp_dut_in_valid_low", dut_in_valid, 0);
    @(posedge clk); #2;
    release_cnt = 1;
    repeat (5) @(negedge clk);
    chk("bp_fires_after_release", 64'(fire_idx), 9);
    chk("bp_refire_latency", 64'(last_fire_cyc), 64'(last_out_cyc + 1));
    chk("bp_test_count", test_count, 1);

    // Result with nothing in flight.
    do_reset(0, "");
    load_and_start(0, -1, 0, 0);
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    inject_stray = 1;
    repeat (4) @(negedge clk);
    chk("stray_proto_err", proto_err, 1);
    chk("stray_counts", {test_count, error_count}, 0);
    chk("stray_busy", busy, 1);
    chk("stray_no_mm", 64'(mm_seen), 0);

    // Reset while draining with a mismatch already recorded.
    do_reset(0, "");
    load_and_start(3, 0, 0, 1);
    for (int i = 0; i < 50 && fire_idx < 3; i++) @(negedge clk);
    @(posedge clk); #2;
    release_cnt = 1;
    repeat (5) @(negedge clk);
    chk("drain_busy", busy, 1);
    chk("drain_error_count", error_count, 1);
    chk("drain_test_count", test_count, 1);
    do_reset(1, "drain_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
